hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
REQ-006 id_rd  in  5  ID destination index.
REQ-007 id_we  in  1  ID instruction writes the register file.
REQ-008 id_is_load  in  1  ID instruction is a data-memory load.
REQ-009 ex_branch_taken  in  1  EX-stage branch or jump resolved as taken this cycle.
REQ-010 stall_pc, stall_ifid  out  1 each  hold PC and IF/ID this cycle.
REQ-011 bubble_idex  out  1  ID/EX captures a no-op this cycle: we=0, store=0, rd=0.
REQ-012 flush_ifid  out  1  IF/ID captures a no-op this cycle.
REQ-013 fwd_a, fwd_b  out  2 each  EX operand select: 00 = ID/EX data, 01 = EX/MEM result, 10 = MEM/WB result; registered and aligned with the EX instruction.
REQ-014 stall_cnt, flush_cnt  out  32 each  saturating performance counters.

Function
REQ-015 The block SHALL keep a 3-entry scoreboard (EX, MEM, WB), each entry {valid, rd, we, load}.
REQ-016 A hazard match SHALL require: entry valid, entry we=1, entry rd != 0, the ID source used, and rd equal to that source.
REQ-017 Load-use: a match against the EX entry with load=1 SHALL assert stall_pc, stall_ifid and bubble_idex combinationally in the same cycle.
REQ-018 ex_branch_taken=1 SHALL assert flush_ifid and bubble_idex, SHALL force all stall outputs to 0, and SHALL override a simultaneous load-use hazard.
REQ-019 On each edge, the scoreboard SHALL shift: WB<-MEM, MEM<-EX.
REQ-020 On each edge, EX<-{id_valid, id_rd, id_we, id_is_load}, unless bubble_idex=1, in which case EX<-invalid.
REQ-021 fwd_x next value:
- 01 if the source matches the EX entry (non-load);
- else 10 if it matches the MEM entry;
- else 00.
- An EX match SHALL take priority over a MEM match.
REQ-022 fwd_x SHALL register to 00 whenever bubble_idex=1.
REQ-023 A WB-entry match SHALL NOT forward; the register file is write-first.
REQ-024 Exactly one bubble SHALL be inserted per load-use hazard. On the following cycle the load occupies MEM, the stall releases, and fwd SHALL register 10.
REQ-025 stall_cnt SHALL increment on each cycle with stall_pc=1; flush_cnt SHALL increment on each cycle with flush_ifid=1.
REQ-026 Both counters SHALL saturate at 0xFFFF_FFFF.
REQ-027 id_valid=0 SHALL produce no hazard and no forwarding.
REQ-028 rd=0 SHALL never match.

Reset
REQ-029 While rst_n=0:
- all scoreboard valid bits 0;
- fwd_a and fwd_b 00;
- stall_cnt and flush_cnt 0;
- combinational outputs 0, because every entry is invalid.
REQ-030 Reset asserted mid-stall SHALL immediately deassert stall_pc, stall_ifid and bubble_idex.
REQ-031 After rst_n deasserts, the first edge SHALL load the scoreboard normally.

Structure
REQ-032 The forwarding-select encodings (FWD_ID=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10) and the scoreboard entry record SHALL live in the shared pipeline package.
REQ-033 Match logic SHALL be one sub-module, hazard_match (entry + source -> hit), instantiated once per entry-source pair.

Verification
REQ-034 "add x5" then "add x6,x5,x1" back-to-back -> no stall; fwd_a=01 in the second instruction's EX cycle.
REQ-035 "lw x5" then "add x6,x5,x5" -> stall_pc/stall_ifid/bubble_idex high for exactly 1 cycle; then fwd_a=fwd_b=10; stall_cnt=1.
REQ-036 "lw x5" with a dependent instruction in ID while ex_branch_taken=1 -> flush_ifid=1, bubble_idex=1, stall_pc=0; flush_cnt=1.
REQ-037 A producer writing x0, followed by a consumer of x0 -> fwd 00, no stall.
REQ-038 "add x7" in MEM and "add x7" in EX, consumer of x7 -> fwd 01 (newest producer wins).
REQ-039 rst_n pulled low during a load-use stall -> stall outputs 0 asynchronously, fwd 00, counters 0; clean restart on the next edge.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: scoreboard entry record, forwarding-select codes
// and small helpers used by the hazard unit and its match cells.
package hazard_unit_pkg;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 32;
  localparam int NUM_SRC = 2;

  // Scoreboard slots, youngest first.
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  typedef enum logic [1:0] {
    FWD_ID    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // An invalid instruction carries no producer information at all.
  function automatic sb_entry_t sb_pack(input logic valid, input logic [REG_W-1:0] rd,
                                        input logic we, input logic load);
    sb_entry_t e;
    e = SB_EMPTY;
    if (valid) begin
      e.valid = 1'b1;
      e.rd    = rd;
      e.we    = we;
      e.load  = load;
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// One scoreboard entry compared against one ID source register.
// hit_load_o flags a match against a load still waiting for its data.
module hazard_match
  import hazard_unit_pkg::*;
(
  input  sb_entry_t        entry_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  output logic             hit_o,
  output logic             hit_load_o
);

  // x0 is hardwired, so a producer targeting it never creates a dependency.
  assign hit_o = entry_i.valid & entry_i.we & (entry_i.rd != '0) &
                 use_i & (entry_i.rd == src_i);

  assign hit_load_o = hit_o & entry_i.load;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX/MEM/WB producer scoreboard, load-use stall,
// branch flush, registered operand-forwarding selects and perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t        sb_q [SB_DEPTH];
  sb_entry_t        ex_d;
  fwd_sel_e         fwd_q [NUM_SRC];
  fwd_sel_e         fwd_d [NUM_SRC];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [REG_W-1:0] src_w      [NUM_SRC];
  logic             use_w      [NUM_SRC];
  logic             hit_w      [SB_DEPTH][NUM_SRC];
  logic             hit_load_w [SB_DEPTH][NUM_SRC];

  logic load_use_w;
  logic flush_w;
  logic stall_w;
  logic bubble_w;

  assign src_w[0] = id_rs1;
  assign src_w[1] = id_rs2;
  assign use_w[0] = id_valid & id_use_rs1;
  assign use_w[1] = id_valid & id_use_rs2;

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
      for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_src
        hazard_match u_match (
          .entry_i    (sb_q[gi]),
          .src_i      (src_w[gj]),
          .use_i      (use_w[gj]),
          .hit_o      (hit_w[gi][gj]),
          .hit_load_o (hit_load_w[gi][gj])
        );
      end
    end
  endgenerate

  // A taken branch kills the ID instruction anyway, so it overrides any stall.
  assign load_use_w = hit_load_w[SB_EX][0] | hit_load_w[SB_EX][1];
  assign flush_w    = rst_n & ex_branch_taken;
  assign stall_w    = rst_n & load_use_w & ~ex_branch_taken;
  assign bubble_w   = flush_w | stall_w;

  assign stall_pc    = stall_w;
  assign stall_ifid  = stall_w;
  assign bubble_idex = bubble_w;
  assign flush_ifid  = flush_w;

  assign ex_d = bubble_w ? SB_EMPTY : sb_pack(id_valid, id_rd, id_we, id_is_load);

  // Newest producer wins; a WB match reads the write-first register file.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_d[i] = FWD_ID;
      if (bubble_w) begin
        fwd_d[i] = FWD_ID;
      end else if (hit_w[SB_EX][i] && !hit_load_w[SB_EX][i]) begin
        fwd_d[i] = FWD_EXMEM;
      end else if (hit_w[SB_MEM][i]) begin
        fwd_d[i] = FWD_MEMWB;
      end else if (hit_w[SB_WB][i]) begin
        fwd_d[i] = FWD_ID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= SB_EMPTY;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_q[i] <= FWD_ID;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q[SB_WB]  <= sb_q[SB_MEM];
      sb_q[SB_MEM] <= sb_q[SB_EX];
      sb_q[SB_EX]  <= ex_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_q[i] <= fwd_d[i];
      end
      stall_cnt_q <= sat_inc(stall_cnt_q, stall_w);
      flush_cnt_q <= sat_inc(flush_cnt_q, flush_w);
    end
  end

  assign fwd_a     = fwd_q[0];
  assign fwd_b     = fwd_q[1];
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expectations are queued as each ID
// instruction is driven and popped when the matching DUT output is sampled.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_use_rs1 = 1'b0;
  logic        id_use_rs2 = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_is_load = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        stall_pc;
  logic        stall_ifid;
  logic        bubble_idex;
  logic        flush_ifid;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  hazard_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_we           (id_we),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (stall_pc),
    .stall_ifid      (stall_ifid),
    .bubble_idex     (bubble_idex),
    .flush_ifid      (flush_ifid),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_STALL_PC, S_STALL_IFID, S_BUBBLE, S_FLUSH,
    S_FWD_A, S_FWD_B, S_STALL_CNT, S_FLUSH_CNT
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_STALL_PC:   return 32'(stall_pc);
      S_STALL_IFID: return 32'(stall_ifid);
      S_BUBBLE:     return 32'(bubble_idex);
      S_FLUSH:      return 32'(flush_ifid);
      S_FWD_A:      return 32'(fwd_a);
      S_FWD_B:      return 32'(fwd_b);
      S_STALL_CNT:  return stall_cnt;
      S_FLUSH_CNT:  return flush_cnt;
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sig);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s/%s observed=%0h expected=%0h", e.tag, e.sig.name(), obs, e.exp);
      end
    end
  endtask

  task automatic expect_comb(input string tag, input int sp, input int bub, input int fl);
    expect_val(tag, S_STALL_PC, 32'(sp));
    expect_val(tag, S_STALL_IFID, 32'(sp));
    expect_val(tag, S_BUBBLE, 32'(bub));
    expect_val(tag, S_FLUSH, 32'(fl));
  endtask

  task automatic expect_reg(input string tag, input int fa, input int fb);
    expect_val(tag, S_FWD_A, 32'(fa));
    expect_val(tag, S_FWD_B, 32'(fb));
    expect_val(tag, S_STALL_CNT, 32'(exp_sc));
    expect_val(tag, S_FLUSH_CNT, 32'(exp_fc));
  endtask

  task automatic set_id(input int v, input int rd, input int we, input int ld,
                        input int rs1, input int u1, input int rs2, input int u2, input int br);
    id_valid        = (v != 0);
    id_rd           = 5'(rd);
    id_we           = (we != 0);
    id_is_load      = (ld != 0);
    id_rs1          = 5'(rs1);
    id_use_rs1      = (u1 != 0);
    id_rs2          = 5'(rs2);
    id_use_rs2      = (u2 != 0);
    ex_branch_taken = (br != 0);
  endtask

  // One ID cycle: comb outputs checked mid-cycle, registered outputs after the edge.
  task automatic step(input string tag, input int v, input int rd, input int we, input int ld,
                      input int rs1, input int u1, input int rs2, input int u2, input int br,
                      input int sp, input int bub, input int fl, input int fa, input int fb);
    @(negedge clk);
    set_id(v, rd, we, ld, rs1, u1, rs2, u2, br);
    expect_comb(tag, sp, bub, fl);
    if (sp != 0) exp_sc++;
    if (fl != 0) exp_fc++;
    #1;
    drain();
    @(posedge clk);
    #1;
    expect_reg(tag, fa, fb);
    drain();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // Reset with a would-be hazard on the ID inputs.
    set_id(1, 6, 1, 0, 5, 1, 5, 1, 0);
    #2;
    expect_comb("reset", 0, 0, 0);
    expect_reg("reset", 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU producer followed by consumer: EX/MEM forward, no stall.
    step("t034_add_x5", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t034_add_x6", 1, 6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Load-use: one bubble, then MEM/WB forward on both operands.
    step("t035_lw_x5",   1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t035_stall",   1, 6, 1, 0, 5, 1, 5, 1, 0, 1, 1, 0, 0, 0);
    step("t035_release", 1, 6, 1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 2, 2);
    idle(3);

    // Taken branch overrides the load-use stall; invalid ID never forwards.
    step("t036_lw_x5",  1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t036_branch", 1, 6, 1, 0, 5, 1, 5, 1, 1, 0, 1, 1, 0, 0);
    step("t036_noid",   0, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // x0 producers never match.
    step("t037_lw_x0",   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t037_use_x0",  1, 6, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step("t037_add_x0",  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t037_use_x0b", 1, 9, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Two producers of x7: newest wins; then MEM-only, then WB-only (no forward).
    step("t038_add_x7a", 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t038_add_x7b", 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t038_use_ex",  1, 10, 0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 1, 1);
    step("t038_use_mem", 1, 10, 0, 0, 7, 1, 7, 0, 0, 0, 0, 0, 2, 0);
    step("t038_use_wb",  1, 10, 0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Reset pulled mid-stall with a forward select and counters non-zero.
    step("t039_add_x11", 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t039_lw_x5",   1, 5, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    set_id(1, 6, 1, 0, 5, 1, 5, 1, 0);
    expect_comb("t039_prestall", 1, 1, 0);
    #1;
    drain();
    #1;
    rst_n = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    #1;
    expect_comb("t039_in_reset", 0, 0, 0);
    expect_reg("t039_in_reset", 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t039_lw_x9",   1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t039_use_x9",  1, 12, 1, 0, 9, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    step("t039_release", 1, 12, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 2, 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
